// File: rtl/sar_adc_avg.sv
// sar_adc_avg: sequencer and averaging consumer for the 8-bit SAR ADC stage.
// Paces ADC conversions from a programmable sample-period divider, sums
// 2^p_avg_log2 results and presents their average on a valid/ready output.
// Optional build macro SAR_ADC_AVG_ROUND_EN: round-half-up and saturate the
// average instead of truncating it.
module sar_adc_avg #(
    parameter int p_bit_cnt  = 8,
    parameter int p_avg_log2 = 2,
    parameter int p_div_bits = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic [p_div_bits-1:0] i_div,
    output logic                  o_adc_start,
    input  logic                  i_adc_busy,
    input  logic [p_bit_cnt-1:0]  i_adc_res,
    input  logic                  i_adc_valid,
    output logic [p_bit_cnt-1:0]  o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_overrun
);

    // Sum of 2^p_avg_log2 full-scale samples always fits in acc_w bits.
    localparam int acc_w = p_bit_cnt + p_avg_log2;
    localparam int cnt_w = p_avg_log2 + 1;
    localparam logic [cnt_w-1:0] cnt_full = {{(cnt_w-1){1'b0}}, 1'b1} << p_avg_log2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_START,
        S_ARM,
        S_CONV
    } state_t;

    state_t                  state;
    logic [p_div_bits-1:0]   div_cnt;
    logic                    div_tick;
    logic [acc_w-1:0]        acc;
    logic [acc_w-1:0]        acc_next;
    logic [cnt_w-1:0]        cnt;
    logic [cnt_w-1:0]        cnt_next;

`ifdef SAR_ADC_AVG_ROUND_EN
    // Half an LSB of the output, expressed in accumulator units (0 when no averaging).
    localparam logic [acc_w:0] round_half = (acc_w+1)'((1 << p_avg_log2) >> 1);
    localparam logic [acc_w:0] sat_max    = {{(acc_w+1-p_bit_cnt){1'b0}}, {p_bit_cnt{1'b1}}};

    function automatic logic [acc_w:0] round_shift(input logic [acc_w-1:0] total);
        logic [acc_w:0] sum;
        sum = {1'b0, total} + round_half;
        return sum >> p_avg_log2;
    endfunction

    function automatic logic [p_bit_cnt-1:0] sat_out(input logic [acc_w:0] val);
        logic [acc_w:0] clipped;
        clipped = (val > sat_max) ? sat_max : val;
        return clipped[p_bit_cnt-1:0];
    endfunction

    function automatic logic [p_bit_cnt-1:0] avg_of(input logic [acc_w-1:0] total);
        return sat_out(round_shift(total));
    endfunction
`else
    function automatic logic [p_bit_cnt-1:0] avg_of(input logic [acc_w-1:0] total);
        logic [acc_w-1:0] shifted;
        shifted = total >> p_avg_log2;
        return shifted[p_bit_cnt-1:0];
    endfunction
`endif

    assign div_tick = i_enable && (div_cnt == i_div);
    assign acc_next = acc + acc_w'(i_adc_res);
    assign cnt_next = cnt + cnt_w'(1);

    // Sample-period divider: free-runs 0..i_div while enabled, parked at 0 otherwise.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            div_cnt <= '0;
        end else if (!i_enable || div_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Conversion sequencer, accumulator and output register with overrun flag.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= S_IDLE;
            o_adc_start <= 1'b0;
            acc         <= '0;
            cnt         <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            o_adc_start <= 1'b0;
            // A plain handshake empties the register; a same-edge load below overrides it.
            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (i_enable) begin
                        state     <= S_WAIT;
                        o_overrun <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (!i_enable) begin
                        state <= S_IDLE;
                        acc   <= '0;
                        cnt   <= '0;
                    end else if (div_tick) begin
                        state       <= S_START;
                        o_adc_start <= 1'b1;
                    end
                end
                S_START: begin
                    state <= S_ARM;
                end
                S_ARM: begin
                    // Valid may still be high from the previous conversion; only busy counts here.
                    if (i_adc_busy) begin
                        state <= S_CONV;
                    end
                end
                S_CONV: begin
                    if (i_adc_valid) begin
                        state <= S_WAIT;
                        if (cnt_next == cnt_full) begin
                            acc <= '0;
                            cnt <= '0;
                            if (!o_valid || i_ready) begin
                                o_data  <= avg_of(acc_next);
                                o_valid <= 1'b1;
                            end else begin
                                o_overrun <= 1'b1;
                            end
                        end else begin
                            acc <= acc_next;
                            cnt <= cnt_next;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sar_adc_avg.md
Name: sar_adc_avg

Overview:
- Downstream consumer and sequencer for the 8-bit SAR ADC stage.
- Paces conversions at a programmable sample period by driving the ADC start/busy/valid control port.
- Accumulates 2^p_avg_log2 consecutive results and emits their average on a valid/ready stream.
- Sits between the SAR ADC and the sample FIFO / register interface.

Parameters:
- p_bit_cnt, 8, ADC result width; must match the ADC instance.
- p_avg_log2, 2, log2 of samples per average (0..6); 0 = pass-through.
- p_div_bits, 16, width of the sample-period divider input.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous reset, active-high
- i_enable  in  1  run conversions while high
- i_div  in  p_div_bits  sample period minus one, in clocks
- o_adc_start  out  1  one-cycle start pulse to ADC
- i_adc_busy  in  1  ADC busy
- i_adc_res  in  p_bit_cnt  ADC result
- i_adc_valid  in  1  ADC result valid; level, held until next start
- o_data  out  p_bit_cnt  averaged sample
- o_valid  out  1  o_data valid
- i_ready  in  1  downstream accepts o_data
- o_overrun  out  1  sticky: an average was dropped

Behaviour:
- Reset values:
  - o_adc_start=0, o_valid=0, o_data=0, o_overrun=0.
  - FSM=IDLE, accumulator=0, sample count=0, divider=0.
- Accumulator width is p_bit_cnt+p_avg_log2, so it never overflows. Sample count is p_avg_log2+1 bits.
- Divider:
  - Counts 0..i_div while i_enable=1 and wraps; tick when count==i_div; held at 0 while i_enable=0.
  - i_div=0 gives a tick every cycle.
- FSM states: IDLE, WAIT, START, ARM, CONV.
  - IDLE: i_enable=1 -> WAIT.
  - WAIT:
    - i_enable=0 -> IDLE; clears accumulator and count.
    - Otherwise tick -> START.
    - A tick that occurs outside WAIT is lost. Start is issued on the first tick seen in WAIT.
  - START: o_adc_start=1 for exactly this cycle -> ARM.
  - ARM:
    - Wait for i_adc_busy=1, then -> CONV.
    - i_adc_valid is ignored in ARM, because the ADC may still hold valid from its previous conversion.
  - CONV: on i_adc_valid=1, in the same edge:
    - accumulator += i_adc_res; count += 1.
    - If count reaches 2^p_avg_log2:
      - Compute the average = accumulator_total >> p_avg_log2.
      - Attempt the output load.
      - Clear accumulator and count.
    - Then -> WAIT. i_enable=0 is honoured only after the conversion completes.
- Output register:
  - Loads when (o_valid=0 or i_ready=1) at the average edge; o_valid=1 the next cycle.
  - Holds o_data and o_valid stable until an i_ready=1 handshake.
  - Handshake with no new load -> o_valid=0.
  - Load with o_valid=1 and i_ready=1 in the same cycle -> o_valid stays 1 with new data.
  - If the register is occupied and i_ready=0, the new average is dropped and o_overrun=1.
  - o_overrun is cleared only by reset or by an IDLE->WAIT transition.
- Latency: o_valid rises 1 clock after the final i_adc_valid edge captured in CONV.
- Reset mid-conversion:
  - All state returns to reset values; o_adc_start stays 0.
  - The ADC's own reset is external and shares i_reset.

Optional Feature:
- Macro SAR_ADC_AVG_ROUND_EN.
  - Defined: average = (accumulator_total + 2^(p_avg_log2-1)) >> p_avg_log2, saturated to 2^p_bit_cnt-1. No effect when p_avg_log2=0.
  - Undefined: truncating shift only, with no rounding adder.

Test Plan:
- p_avg_log2=2, i_div=9, ADC model returns 10,11,12,13, i_ready=1 -> o_data=11 (truncate), or 12 with SAR_ADC_AVG_ROUND_EN; one-cycle o_valid.
- i_div=9, ADC conversion 10 clocks with i_enable=1 -> o_adc_start pulses exactly one cycle each. Every second tick is missed, so consecutive pulses are 20 clocks apart.
- i_ready=0 held across two complete averages -> first average held stable on o_data; second dropped; o_overrun=1. Then i_ready=1 -> first value accepted, o_valid=0.
- ADC holds i_adc_valid=1 from its prior conversion when the next start issues -> the stale value is not accumulated; the count advances only after busy then valid.
- i_enable=0 during CONV -> conversion completes and is accumulated, then IDLE; re-enable -> accumulator and count start from 0, o_overrun cleared.
- i_reset=1 for 1 cycle mid-CONV with 2 samples accumulated -> all outputs 0 next cycle; the next average uses only 4 fresh samples.
